// File: rtl/nvram_sector_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : nvram_sector_seq                                              |
// | Brief    : Sector-by-sector load/save sequencer for an NVRAM save slot.  |
// |            Optional HPS watchdog enabled by defining NVSEQ_TIMEOUT_EN.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module nvram_sector_seq #(
  parameter int SLOTS     = 4,
  parameter int SECT_LOG2 = 6,
  parameter int TMO_W     = 20
) (
  input  logic                                          clk_sys,
  input  logic                                          RESET_n,
  input  logic                                          ena,
  input  logic                                          load_req,
  input  logic                                          save_req,
  input  logic [((SLOTS > 1) ? $clog2(SLOTS) : 1)-1:0] slot,
  input  logic                                          nvram_we,
  output logic [31:0]                                   sd_lba,
  output logic                                          sd_rd,
  output logic                                          sd_wr,
  input  logic                                          sd_ack,
  output logic                                          busy,
  output logic                                          loading,
  output logic                                          dirty,
  output logic                                          error,
  output logic                                          done
);

  localparam int                       c_SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [c_SLOT_W-1:0]      c_SLOT_MAX  = c_SLOT_W'(SLOTS - 1);
  localparam logic [SECT_LOG2-1:0]     c_SECT_LAST = '1;

  if (SLOTS < 1 || SLOTS > 16) begin : g_bad_slots
    $error("nvram_sector_seq: SLOTS must be 1..16");
  end
  if (SECT_LOG2 < 1 || SECT_LOG2 > 8) begin : g_bad_sect
    $error("nvram_sector_seq: SECT_LOG2 must be 1..8");
  end
  if (TMO_W < 1) begin : g_bad_tmo
    $error("nvram_sector_seq: TMO_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_load_q, r_save_q, r_ack_q;
  logic [c_SLOT_W-1:0]    r_slot, w_slot_nxt;
  logic [SECT_LOG2-1:0]   r_sector, w_sector_nxt;
  logic                   r_rd, w_rd_nxt;
  logic                   r_wr, w_wr_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_loading, w_loading_nxt;
  logic                   r_dirty, w_dirty_nxt;
  logic                   w_load_rise, w_save_rise, w_start;
  logic                   w_ack_rise, w_ack_fall;
  logic                   w_tmo_hit;
`ifdef NVSEQ_TIMEOUT_EN
  logic [TMO_W-1:0]       r_tmo;
  logic                   r_error;
  logic                   w_err_set, w_err_clr;
`endif

  assign w_load_rise = load_req & ena & ~r_load_q;
  assign w_save_rise = save_req & ena & ~r_save_q;
  assign w_start     = w_load_rise | w_save_rise;
  assign w_ack_rise  = sd_ack & ~r_ack_q;
  assign w_ack_fall  = ~sd_ack & r_ack_q;

  always_comb begin
    w_state_nxt   = r_state;
    w_slot_nxt    = r_slot;
    w_sector_nxt  = r_sector;
    w_rd_nxt      = r_rd;
    w_wr_nxt      = r_wr;
    w_busy_nxt    = r_busy;
    w_loading_nxt = r_loading;
`ifdef NVSEQ_TIMEOUT_EN
    w_err_set     = 1'b0;
    w_err_clr     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt   = S_REQ;
          w_slot_nxt    = (slot > c_SLOT_MAX) ? c_SLOT_MAX : slot;
          w_sector_nxt  = '0;
          w_loading_nxt = w_load_rise;
          w_rd_nxt      = w_load_rise;
          w_wr_nxt      = ~w_load_rise;
          w_busy_nxt    = 1'b1;
`ifdef NVSEQ_TIMEOUT_EN
          w_err_clr     = 1'b1;
`endif
        end
      end
      S_REQ: begin
        if (w_tmo_hit) begin
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_state_nxt = S_DONE;
`ifdef NVSEQ_TIMEOUT_EN
          w_err_set   = 1'b1;
`endif
        end else if (w_ack_rise) begin
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
`ifdef NVSEQ_TIMEOUT_EN
          w_err_set   = 1'b1;
`endif
        end else if (w_ack_fall) begin
          if (r_sector == c_SECT_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_sector_nxt = r_sector + SECT_LOG2'(1);
            w_rd_nxt     = r_loading;
            w_wr_nxt     = ~r_loading;
            w_state_nxt  = S_REQ;
          end
        end
      end
      S_DONE: begin
        w_state_nxt   = S_IDLE;
        w_busy_nxt    = 1'b0;
        w_loading_nxt = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A core write in the save start cycle must win so that write is not lost.
    w_dirty_nxt = r_dirty;
    if (r_state == S_DONE && r_loading)
      w_dirty_nxt = 1'b0;
    else if (nvram_we && !r_loading)
      w_dirty_nxt = 1'b1;
    else if (r_state == S_IDLE && w_save_rise && !w_load_rise)
      w_dirty_nxt = 1'b0;
  end

  // Request history resets as "already high" so a level held through reset needs a fresh edge.
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      r_state   <= S_IDLE;
      r_load_q  <= 1'b1;
      r_save_q  <= 1'b1;
      r_ack_q   <= 1'b0;
      r_slot    <= '0;
      r_sector  <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_busy    <= 1'b0;
      r_loading <= 1'b0;
      r_dirty   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_load_q  <= load_req & ena;
      r_save_q  <= save_req & ena;
      r_ack_q   <= sd_ack;
      r_slot    <= w_slot_nxt;
      r_sector  <= w_sector_nxt;
      r_rd      <= w_rd_nxt;
      r_wr      <= w_wr_nxt;
      r_busy    <= w_busy_nxt;
      r_loading <= w_loading_nxt;
      r_dirty   <= w_dirty_nxt;
    end
  end

`ifdef NVSEQ_TIMEOUT_EN
  assign w_tmo_hit = ((r_state == S_REQ) || (r_state == S_XFER)) && (r_tmo == '1);

  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      r_tmo   <= '0;
      r_error <= 1'b0;
    end else begin
      if ((w_state_nxt != r_state) && ((w_state_nxt == S_REQ) || (w_state_nxt == S_XFER)))
        r_tmo <= '0;
      else if ((r_state == S_REQ) || (r_state == S_XFER))
        r_tmo <= r_tmo + TMO_W'(1);
      if (w_err_clr)
        r_error <= 1'b0;
      else if (w_err_set)
        r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign w_tmo_hit = 1'b0;
  assign error     = 1'b0;
`endif

  assign sd_lba  = (32'(r_slot) << SECT_LOG2) | 32'(r_sector);
  assign sd_rd   = r_rd;
  assign sd_wr   = r_wr;
  assign busy    = r_busy;
  assign loading = r_loading;
  assign dirty   = r_dirty;
  assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_nvram_sector_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_nvram_sector_seq                                           |
// | Brief    : Scoreboard bench for nvram_sector_seq with a simple HPS model.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_nvram_sector_seq;

  localparam int SLOTS     = 4;
  localparam int SECT_LOG2 = 6;
  localparam int TMO_W     = 8;
  localparam int NSECT     = 64;

  localparam int EV_RD   = 0;
  localparam int EV_WR   = 1;
  localparam int EV_DONE = 2;

  logic        clk_sys  = 1'b0;
  logic        RESET_n  = 1'b0;
  logic        ena      = 1'b0;
  logic        load_req = 1'b0;
  logic        save_req = 1'b0;
  logic [1:0]  slot     = 2'd0;
  logic        nvram_we = 1'b0;
  logic        sd_ack   = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, busy, loading, dirty, error, done;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  bit hps_en   = 1'b1;
  bit p_rd     = 1'b0;
  bit p_wr     = 1'b0;
  bit p_done   = 1'b0;

  typedef struct {
    int          kind;
    logic [31:0] lba;
    logic        err;
  } ev_t;
  ev_t sb[$];

  nvram_sector_seq #(
    .SLOTS     (SLOTS),
    .SECT_LOG2 (SECT_LOG2),
    .TMO_W     (TMO_W)
  ) dut (
    .clk_sys  (clk_sys),
    .RESET_n  (RESET_n),
    .ena      (ena),
    .load_req (load_req),
    .save_req (save_req),
    .slot     (slot),
    .nvram_we (nvram_we),
    .sd_lba   (sd_lba),
    .sd_rd    (sd_rd),
    .sd_wr    (sd_wr),
    .sd_ack   (sd_ack),
    .busy     (busy),
    .loading  (loading),
    .dirty    (dirty),
    .error    (error),
    .done     (done)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void push_seq(int kind, int base, int n, bit add_done, bit err);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.kind = kind;
      e.lba  = 32'(base + i);
      e.err  = 1'b0;
      sb.push_back(e);
    end
    if (add_done) begin
      e.kind = EV_DONE;
      e.lba  = 32'd0;
      e.err  = err;
      sb.push_back(e);
    end
  endfunction

  function automatic void observe(int k);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d lba %0d, expected no event", k, sd_lba);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || (k != EV_DONE && e.lba != sd_lba) || (k == EV_DONE && e.err != error)) begin
        errors++;
        $display("FAIL event: got kind %0d lba %0d err %0b, expected kind %0d lba %0d err %0b",
                 k, sd_lba, error, e.kind, e.lba, e.err);
      end
    end
    if (k == EV_DONE) done_cnt++;
  endfunction

  // Monitor: every request rising edge and done pulse is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (sd_rd && !p_rd)     observe(EV_RD);
      if (sd_wr && !p_wr)     observe(EV_WR);
      if (done && !p_done)    observe(EV_DONE);
      if (sd_rd && sd_wr)     chk("rd_wr_exclusive", 32'(sd_rd & sd_wr), 0);
      p_rd   = sd_rd;
      p_wr   = sd_wr;
      p_done = done;
    end
  end

  // HPS model: acknowledge two cycles after a request, hold ack for three cycles.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (hps_en && (sd_rd || sd_wr) && !sd_ack) begin
        repeat (2) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (3) @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_done(input string nm);
    int n0;
    int t;
    n0 = done_cnt;
    t  = 0;
    while (done_cnt == n0 && t < 3000) begin
      @(negedge clk_sys);
      t++;
    end
    chk({nm, "_done_seen"}, 32'(done_cnt != n0), 1);
    @(negedge clk_sys);
    chk({nm, "_busy_after"}, 32'(busy), 0);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  initial begin
    int t;
    RESET_n = 1'b0;
    cyc(3);
    chk("rst_flags", 32'({sd_rd, sd_wr, busy, loading, done, error, dirty}), 0);
    chk("rst_lba", sd_lba, 0);
    RESET_n = 1'b1;
    ena     = 1'b1;
    cyc(2);

    nvram_we = 1'b1;
    cyc(1);
    nvram_we = 1'b0;
    chk("dirty_set_by_we", 32'(dirty), 1);

    // Save slot 2 with a core write in the start cycle
    push_seq(EV_WR, 128, NSECT, 1'b1, 1'b0);
    slot     = 2'd2;
    save_req = 1'b1;
    nvram_we = 1'b1;
    cyc(1);
    nvram_we = 1'b0;
    chk("save2_busy", 32'(busy), 1);
    chk("save2_loading", 32'(loading), 0);
    chk("dirty_we_in_save_start", 32'(dirty), 1);
    cyc(3);
    save_req = 1'b0;
    wait_done("save_slot2");

    // Save slot 3: dirty clears at start; a load edge while busy is dropped
    chk("dirty_before_save3", 32'(dirty), 1);
    push_seq(EV_WR, 192, NSECT, 1'b1, 1'b0);
    slot     = 2'd3;
    save_req = 1'b1;
    cyc(1);
    chk("dirty_clr_save_start", 32'(dirty), 0);
    slot = 2'd0;
    cyc(20);
    load_req = 1'b1;
    cyc(3);
    load_req = 1'b0;
    save_req = 1'b0;
    wait_done("save_slot3");

    // Simultaneous load and save edges: load wins, core writes ignored while loading
    push_seq(EV_RD, 0, NSECT, 1'b1, 1'b0);
    slot     = 2'd0;
    load_req = 1'b1;
    save_req = 1'b1;
    cyc(1);
    chk("load_loading", 32'(loading), 1);
    chk("load_busy", 32'(busy), 1);
    cyc(10);
    nvram_we = 1'b1;
    cyc(1);
    nvram_we = 1'b0;
    chk("dirty_we_during_load", 32'(dirty), 0);
    load_req = 1'b0;
    save_req = 1'b0;
    wait_done("load_slot0");
    chk("load_dirty_after", 32'(dirty), 0);
    chk("load_loading_after", 32'(loading), 0);

    // Reset after sector 10 ack rise with save_req held high
    push_seq(EV_WR, 64, 11, 1'b0, 1'b0);
    slot     = 2'd1;
    save_req = 1'b1;
    t = 0;
    while (!(sd_ack && sd_lba == 32'd74) && t < 1000) begin
      cyc(1);
      t++;
    end
    chk("rst_reached_sector10", 32'(sd_ack && sd_lba == 32'd74), 1);
    RESET_n = 1'b0;
    cyc(1);
    RESET_n = 1'b1;
    chk("midrst_flags", 32'({sd_rd, sd_wr, busy, loading, done, error, dirty}), 0);
    chk("midrst_lba", sd_lba, 0);
    cyc(40);
    chk("midrst_no_restart", 32'(busy), 0);
    chk("midrst_sb_empty", 32'(sb.size()), 0);
    save_req = 1'b0;
    cyc(2);
    push_seq(EV_WR, 64, NSECT, 1'b1, 1'b0);
    save_req = 1'b1;
    cyc(2);
    save_req = 1'b0;
    wait_done("save_after_rst");

    // ena gating: held request starts once ena rises
    ena      = 1'b0;
    slot     = 2'd2;
    save_req = 1'b1;
    cyc(10);
    chk("ena0_no_start", 32'(busy), 0);
    push_seq(EV_WR, 128, NSECT, 1'b1, 1'b0);
    ena = 1'b1;
    cyc(2);
    chk("ena1_started", 32'(busy), 1);
    save_req = 1'b0;
    wait_done("save_ena");

    // HPS never acknowledges
    hps_en = 1'b0;
    slot   = 2'd0;
`ifdef NVSEQ_TIMEOUT_EN
    push_seq(EV_RD, 0, 1, 1'b1, 1'b1);
`else
    push_seq(EV_RD, 0, 1, 1'b0, 1'b0);
`endif
    load_req = 1'b1;
    cyc(1);
    load_req = 1'b0;
`ifdef NVSEQ_TIMEOUT_EN
    t = 0;
    while (sd_rd && t < 400) begin
      cyc(1);
      t++;
    end
    chk("tmo_req_cycles_255_256", 32'(t >= 255 && t <= 256), 1);
    chk("tmo_error_set", 32'(error), 1);
    cyc(3);
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_error_hold", 32'(error), 1);
    chk("tmo_sb_empty", 32'(sb.size()), 0);
`else
    cyc(300);
    chk("noack_rd_held", 32'(sd_rd), 1);
    chk("noack_error", 32'(error), 0);
    chk("noack_busy", 32'(busy), 1);
    RESET_n = 1'b0;
    cyc(1);
    RESET_n = 1'b1;
    chk("noack_abort_rd", 32'(sd_rd), 0);
    chk("noack_sb_empty", 32'(sb.size()), 0);
`endif
    hps_en = 1'b1;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
